// File: rtl/arcade_input_cond.sv
// Player-input conditioner: registers and debounces joystick words, optionally merges
// players, resolves opposing directions, and shapes coin edges into queued fixed pulses.
module arcade_input_cond #(
  parameter int PLAYERS   = 2,
  parameter int WIDTH     = 16,
  parameter int COIN_BIT  = 10,
  parameter int DEB_TICKS = 4,
  parameter int COIN_ON   = 8,
  parameter int COIN_OFF  = 8,
  parameter int CNT_W     = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     merge,
  input  logic                     socd_last,
  input  logic [PLAYERS*WIDTH-1:0] joy_in,
  output logic [PLAYERS*WIDTH-1:0] joy_out,
  output logic [PLAYERS-1:0]       coin,
  output logic                     coin_busy,
  output logic [2*PLAYERS-1:0]     coin_state_dbg
);

  localparam int NB = PLAYERS * WIDTH;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_ON   = 2'd1,
    C_OFF  = 2'd2
  } coin_state_t;

  logic [NB-1:0]      a_q;
  logic [NB-1:0]      d_q;
  logic [WIDTH-1:0]   v_or;
  logic [PLAYERS-1:0] busy_vec;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) a_q <= '0;
    else       a_q <= joy_in;
  end

  generate
    if (DEB_TICKS == 0) begin : g_nodeb
      logic [NB-1:0] d_reg;
      always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) d_reg <= '0;
        else       d_reg <= a_q;
      end
      assign d_q = d_reg;
    end else begin : g_deb
      for (genvar b = 0; b < NB; b++) begin : g_bit
        logic             d_bit;
        logic [CNT_W-1:0] cnt;
        // The counter only advances while the registered input disagrees with the stable bit.
        always_ff @(posedge clk_sys or posedge reset) begin
          if (reset) begin
            d_bit <= 1'b0;
            cnt   <= '0;
          end else if (a_q[b] == d_bit) begin
            cnt <= '0;
          end else if (tick) begin
            if (cnt == CNT_W'(DEB_TICKS - 1)) begin
              d_bit <= a_q[b];
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        assign d_q[b] = d_bit;
      end
    end
  endgenerate

  always_comb begin
    v_or = '0;
    for (int p = 0; p < PLAYERS; p++) v_or = v_or | d_q[p*WIDTH +: WIDTH];
  end

  generate
    for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
      logic [WIDTH-1:0] vp;
      logic [WIDTH-1:0] socd_w;
      logic [WIDTH-1:0] out_q;
      logic [7:0]       prev_q;
      logic [3:0]       last_hi_q;
      logic [3:0]       last_hi_nxt;
      logic             coin_prev_q;
      logic             edge_q;
      coin_state_t      state_q;
      coin_state_t      state_nxt;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_nxt;
      logic [1:0]       pend_q;
      logic [1:0]       pend_nxt;

      assign vp = merge ? v_or : d_q[p*WIDTH +: WIDTH];

      // last_hi_nxt[k] = 1 when the odd bit of pair k rose most recently; the even bit wins ties.
      always_comb begin
        socd_w      = vp;
        last_hi_nxt = last_hi_q;
        for (int k = 0; k < 4; k++) begin
          if (vp[2*k] & ~prev_q[2*k])          last_hi_nxt[k] = 1'b0;
          else if (vp[2*k+1] & ~prev_q[2*k+1]) last_hi_nxt[k] = 1'b1;
          if (vp[2*k] & vp[2*k+1]) begin
            if (!socd_last) begin
              socd_w[2*k]   = 1'b0;
              socd_w[2*k+1] = 1'b0;
            end else if (last_hi_nxt[k]) begin
              socd_w[2*k]   = 1'b0;
            end else begin
              socd_w[2*k+1] = 1'b0;
            end
          end
        end
        socd_w[COIN_BIT] = 1'b0;
      end

      always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
          out_q       <= '0;
          prev_q      <= '0;
          last_hi_q   <= '0;
          coin_prev_q <= 1'b0;
          edge_q      <= 1'b0;
        end else begin
          out_q       <= socd_w;
          prev_q      <= vp[7:0];
          last_hi_q   <= last_hi_nxt;
          coin_prev_q <= vp[COIN_BIT];
          edge_q      <= vp[COIN_BIT] & ~coin_prev_q;
        end
      end

      always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
          state_q <= C_IDLE;
          cnt_q   <= '0;
          pend_q  <= '0;
        end else begin
          state_q <= state_nxt;
          cnt_q   <= cnt_nxt;
          pend_q  <= pend_nxt;
        end
      end

      // Edges seen outside IDLE become credits; an edge landing on OFF->IDLE is kept as a credit too.
      always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        pend_nxt  = pend_q;
        case (state_q)
          C_IDLE: begin
            if (edge_q || (pend_q != 2'd0)) begin
              state_nxt = C_ON;
              cnt_nxt   = '0;
              if (!edge_q) pend_nxt = pend_q - 1'b1;
            end
          end
          C_ON: begin
            if (edge_q && (pend_q != 2'd3)) pend_nxt = pend_q + 1'b1;
            if (tick) begin
              if (cnt_q == CNT_W'(COIN_ON - 1)) begin
                state_nxt = C_OFF;
                cnt_nxt   = '0;
              end else begin
                cnt_nxt = cnt_q + 1'b1;
              end
            end
          end
          C_OFF: begin
            if (edge_q && (pend_q != 2'd3)) pend_nxt = pend_q + 1'b1;
            if (tick) begin
              if (cnt_q == CNT_W'(COIN_OFF - 1)) begin
                cnt_nxt = '0;
                if (pend_q != 2'd0) begin
                  state_nxt = C_ON;
                  pend_nxt  = pend_nxt - 1'b1;
                end else begin
                  state_nxt = C_IDLE;
                end
              end else begin
                cnt_nxt = cnt_q + 1'b1;
              end
            end
          end
          default: state_nxt = C_IDLE;
        endcase
      end

      always_comb begin
        coin[p]     = (state_q == C_ON);
        busy_vec[p] = (state_q != C_IDLE) || (pend_q != 2'd0);
      end

      assign joy_out[p*WIDTH +: WIDTH] = out_q;
      assign coin_state_dbg[2*p +: 2]  = state_q;
    end
  endgenerate

  assign coin_busy = |busy_vec;

endmodule

// File: tb/tb_arcade_input_cond.sv
// Directed bench for arcade_input_cond: a bypass-debounce instance for the main paths
// and a DEB_TICKS=4 instance for debounce timing.
module tb_arcade_input_cond;

  logic        clk_sys;
  logic        reset;
  logic        tick;
  logic        merge;
  logic        socd_last;
  logic [31:0] joy_in;
  logic [31:0] joy_out;
  logic [1:0]  coin;
  logic        coin_busy;
  logic [3:0]  dbg;

  logic        tick_db;
  logic [31:0] joy_in_db;
  logic [31:0] joy_out_db;
  logic [1:0]  coin_db;
  logic        busy_db;
  logic [3:0]  dbg_db;

  int errors = 0;
  int checks = 0;

  arcade_input_cond #(.PLAYERS(2), .WIDTH(16), .COIN_BIT(10), .DEB_TICKS(0),
                      .COIN_ON(8), .COIN_OFF(8), .CNT_W(8)) dut (
    .clk_sys(clk_sys), .reset(reset), .tick(tick), .merge(merge), .socd_last(socd_last),
    .joy_in(joy_in), .joy_out(joy_out), .coin(coin), .coin_busy(coin_busy),
    .coin_state_dbg(dbg)
  );

  arcade_input_cond #(.PLAYERS(2), .WIDTH(16), .COIN_BIT(10), .DEB_TICKS(4),
                      .COIN_ON(8), .COIN_OFF(8), .CNT_W(8)) dut_db (
    .clk_sys(clk_sys), .reset(reset), .tick(tick_db), .merge(merge), .socd_last(socd_last),
    .joy_in(joy_in_db), .joy_out(joy_out_db), .coin(coin_db), .coin_busy(busy_db),
    .coin_state_dbg(dbg_db)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (joy_out !== 32'h0) begin errors++; $display("FAIL reset_joy_out: got %h expected %h", joy_out, 32'h0); end
    checks++; if (coin !== 2'b00) begin errors++; $display("FAIL reset_coin: got %b expected %b", coin, 2'b00); end
    checks++; if (coin_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected %b", coin_busy, 1'b0); end
    checks++; if (dbg !== 4'h0) begin errors++; $display("FAIL reset_state: got %h expected %h", dbg, 4'h0); end
    checks++; if (joy_out_db !== 32'h0) begin errors++; $display("FAIL reset_joy_out_db: got %h expected %h", joy_out_db, 32'h0); end
    step(); step();
    reset = 1'b0;
    repeat (3) step();
    checks++; if (joy_out !== 32'h0) begin errors++; $display("FAIL post_reset_joy_out: got %h expected %h", joy_out, 32'h0); end
  endtask

  task automatic test_passthrough();
    joy_in = 32'h0000_0008;
    step(); step();
    checks++; if (joy_out !== 32'h0) begin errors++; $display("FAIL pass_early: got %h expected %h", joy_out, 32'h0); end
    step();
    checks++; if (joy_out !== 32'h0000_0008) begin errors++; $display("FAIL pass_latency: got %h expected %h", joy_out, 32'h0000_0008); end
    #2 reset = 1'b1;
    #1;
    checks++; if (joy_out !== 32'h0) begin errors++; $display("FAIL async_reset_joy: got %h expected %h", joy_out, 32'h0); end
    checks++; if (coin !== 2'b00 || coin_busy !== 1'b0) begin errors++; $display("FAIL async_reset_coin: got %b/%b expected 00/0", coin, coin_busy); end
    step();
    reset  = 1'b0;
    joy_in = 32'h0;
    repeat (4) step();
    checks++; if (joy_out !== 32'h0) begin errors++; $display("FAIL pass_clear: got %h expected %h", joy_out, 32'h0); end
  endtask

  task automatic test_merge();
    merge  = 1'b1;
    joy_in = 32'h0001_0000;
    repeat (3) step();
    checks++; if (joy_out !== 32'h0001_0001) begin errors++; $display("FAIL merge_on: got %h expected %h", joy_out, 32'h0001_0001); end
    merge = 1'b0;
    step();
    checks++; if (joy_out !== 32'h0001_0000) begin errors++; $display("FAIL merge_off: got %h expected %h", joy_out, 32'h0001_0000); end
    joy_in = 32'h0;
    repeat (4) step();
    checks++; if (joy_out !== 32'h0) begin errors++; $display("FAIL merge_clear: got %h expected %h", joy_out, 32'h0); end
  endtask

  task automatic test_socd();
    socd_last = 1'b0;
    joy_in    = 32'h0000_0003;
    repeat (3) step();
    checks++; if (joy_out !== 32'h0) begin errors++; $display("FAIL socd_neutral: got %h expected %h", joy_out, 32'h0); end
    socd_last = 1'b1;
    step();
    checks++; if (joy_out !== 32'h0000_0001) begin errors++; $display("FAIL socd_simul: got %h expected %h", joy_out, 32'h0000_0001); end
    joy_in = 32'h0;
    repeat (4) step();
    joy_in = 32'h0000_0001;
    repeat (4) step();
    checks++; if (joy_out !== 32'h0000_0001) begin errors++; $display("FAIL socd_first: got %h expected %h", joy_out, 32'h0000_0001); end
    joy_in = 32'h0000_0003;
    step(); step();
    checks++; if (joy_out !== 32'h0000_0001) begin errors++; $display("FAIL socd_before: got %h expected %h", joy_out, 32'h0000_0001); end
    step();
    checks++; if (joy_out !== 32'h0000_0002) begin errors++; $display("FAIL socd_last_wins: got %h expected %h", joy_out, 32'h0000_0002); end
    socd_last = 1'b0;
    step();
    checks++; if (joy_out !== 32'h0) begin errors++; $display("FAIL socd_live: got %h expected %h", joy_out, 32'h0); end
    joy_in = 32'h0;
    repeat (4) step();
    socd_last = 1'b1;
    joy_in    = 32'h0000_030C;
    repeat (3) step();
    checks++; if (joy_out !== 32'h0000_0304) begin errors++; $display("FAIL socd_pair2: got %h expected %h", joy_out, 32'h0000_0304); end
    joy_in    = 32'h0;
    socd_last = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_coin_burst();
    logic       exp_coin;
    logic       exp_busy;
    logic [1:0] exp_state;
    logic       prev_c;
    int         pulses;
    prev_c = 1'b0;
    pulses = 0;
    for (int j = 0; j < 80; j++) begin
      joy_in[10] = (j <= 8) && (j % 2 == 0);
      exp_coin  = (j >= 4 && j <= 11) || (j >= 20 && j <= 27) ||
                  (j >= 36 && j <= 43) || (j >= 52 && j <= 59);
      exp_busy  = (j >= 4) && (j <= 67);
      exp_state = exp_coin ? 2'd1 : (exp_busy ? 2'd2 : 2'd0);
      checks++; if (coin !== {1'b0, exp_coin}) begin errors++; $display("FAIL coin_wave j=%0d: got %b expected %b", j, coin, {1'b0, exp_coin}); end
      checks++; if (coin_busy !== exp_busy) begin errors++; $display("FAIL coin_busy j=%0d: got %b expected %b", j, coin_busy, exp_busy); end
      checks++; if (dbg[1:0] !== exp_state) begin errors++; $display("FAIL coin_state j=%0d: got %0d expected %0d", j, dbg[1:0], exp_state); end
      checks++; if (joy_out !== 32'h0) begin errors++; $display("FAIL coin_bit_masked j=%0d: got %h expected %h", j, joy_out, 32'h0); end
      if (coin[0] && !prev_c) pulses++;
      prev_c = coin[0];
      step();
    end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL coin_pulse_count: got %0d expected %0d", pulses, 4); end
  endtask

  task automatic test_reset_mid_pulse();
    for (int j = 0; j < 9; j++) begin
      joy_in[10] = (j <= 4) && (j % 2 == 0);
      step();
    end
    checks++; if (coin !== 2'b01) begin errors++; $display("FAIL mid_pulse_high: got %b expected %b", coin, 2'b01); end
    #2 reset = 1'b1;
    #1;
    checks++; if (coin !== 2'b00) begin errors++; $display("FAIL mid_reset_coin: got %b expected %b", coin, 2'b00); end
    checks++; if (coin_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected %b", coin_busy, 1'b0); end
    checks++; if (dbg !== 4'h0) begin errors++; $display("FAIL mid_reset_state: got %h expected %h", dbg, 4'h0); end
    step(); step();
    reset = 1'b0;
    for (int j = 0; j < 50; j++) begin
      step();
      checks++; if (coin !== 2'b00 || coin_busy !== 1'b0) begin errors++; $display("FAIL after_reset j=%0d: got %b/%b expected 00/0", j, coin, coin_busy); end
    end
  endtask

  task automatic test_debounce();
    logic [31:0] exp_db;
    for (int i = 0; i < 48; i++) begin
      tick_db       = (i % 4 == 3);
      joy_in_db[8]  = (i < 8) || (i >= 24);
      exp_db        = (i >= 41) ? 32'h0000_0100 : 32'h0;
      checks++; if (joy_out_db !== exp_db) begin errors++; $display("FAIL debounce i=%0d: got %h expected %h", i, joy_out_db, exp_db); end
      step();
    end
    tick_db   = 1'b0;
    joy_in_db = 32'h0;
  endtask

  initial begin
    reset     = 1'b1;
    tick      = 1'b1;
    merge     = 1'b0;
    socd_last = 1'b0;
    joy_in    = 32'h0;
    tick_db   = 1'b0;
    joy_in_db = 32'h0;
    test_reset();
    test_passthrough();
    test_merge();
    test_socd();
    test_coin_burst();
    test_reset_mid_pulse();
    test_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
